// File: rtl/cpu_sequencer.sv
// Instruction sequencer: steps the core through READ/LOAD/CALC/WRITE and counts retired instructions.
// Optional RAM stall timeout (into SERR) is compiled in with `define SEQ_STALL_TIMEOUT_EN.
module cpu_sequencer #(
    parameter int                      IP_WIDTH       = 8,
    parameter int                      OPCODE_WIDTH   = 4,
    parameter logic [OPCODE_WIDTH-1:0] HALT_OPCODE    = '1,
    parameter int                      TIMEOUT_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    run,
    input  logic                    ram_busy,
    input  logic [OPCODE_WIDTH-1:0] opcode,
    input  logic [IP_WIDTH-1:0]     ip,
    output logic [2:0]              q,
    output logic                    err,
    output logic                    halted,
    output logic                    retired,
    output logic [15:0]             retire_cnt
);

    typedef enum logic [2:0] {
        SRST   = 3'd0,
        SREAD  = 3'd1,
        SLOAD1 = 3'd2,
        SLOAD2 = 3'd3,
        SCALC  = 3'd4,
        SWRITE = 3'd5,
        SHALT  = 3'd6,
        SERR   = 3'd7
    } state_t;

    state_t      state_reg;
    logic        retired_reg;
    logic [15:0] retire_cnt_reg;
    logic        stall;
    logic        timeout;

    // Only the three RAM-facing states can be stretched by ram_busy.
    assign stall = ram_busy &&
                   ((state_reg == SLOAD1) || (state_reg == SLOAD2) || (state_reg == SWRITE));

`ifdef SEQ_STALL_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] stall_cnt_reg;

    assign timeout = stall && (stall_cnt_reg == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_reg <= '0;
        end else if (!stall) begin
            stall_cnt_reg <= '0;
        end else if (stall_cnt_reg != CNT_LAST) begin
            stall_cnt_reg <= stall_cnt_reg + 1'b1;
        end
    end

    assign err = (state_reg == SERR);
`else
    // Without the timeout the parameter has no effect and SERR cannot be reached.
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES == 0);
    assign timeout        = 1'b0;
    assign err            = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= SRST;
            retired_reg    <= 1'b0;
            retire_cnt_reg <= '0;
        end else begin
            retired_reg <= 1'b0;
            if (timeout) begin
                state_reg <= SERR;
            end else begin
                case (state_reg)
                    SRST:   if (run) state_reg <= SREAD;
                    SREAD:  state_reg <= SLOAD1;
                    SLOAD1: if (!ram_busy) state_reg <= SLOAD2;
                    SLOAD2: begin
                        if (!ram_busy) begin
                            state_reg <= (opcode == HALT_OPCODE) ? SHALT : SCALC;
                        end
                    end
                    SCALC:  state_reg <= SWRITE;
                    SWRITE: begin
                        if (!ram_busy) begin
                            retired_reg <= 1'b1;
                            if (retire_cnt_reg != 16'hFFFF) begin
                                retire_cnt_reg <= retire_cnt_reg + 16'd1;
                            end
                            // Last address halts instead of wrapping the instruction pointer.
                            if (&ip) begin
                                state_reg <= SHALT;
                            end else if (!run) begin
                                state_reg <= SRST;
                            end else begin
                                state_reg <= SREAD;
                            end
                        end
                    end
                    default: state_reg <= state_reg;
                endcase
            end
        end
    end

    assign q          = state_reg;
    assign halted     = (state_reg == SHALT);
    assign retired    = retired_reg;
    assign retire_cnt = retire_cnt_reg;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Scoreboard bench for cpu_sequencer: the driver derives the expected state trace from
// per-instruction stall counts; a negedge monitor pops and compares every cycle.
module tb_cpu_sequencer;

    localparam logic [3:0] HALT    = 4'hF;
    localparam logic [2:0] S_RST   = 3'd0;
    localparam logic [2:0] S_READ  = 3'd1;
    localparam logic [2:0] S_LOAD1 = 3'd2;
    localparam logic [2:0] S_LOAD2 = 3'd3;
    localparam logic [2:0] S_CALC  = 3'd4;
    localparam logic [2:0] S_WRITE = 3'd5;
    localparam logic [2:0] S_HALT  = 3'd6;
    localparam logic [2:0] S_ERR   = 3'd7;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        run = 1'b0;
    logic        ram_busy = 1'b0;
    logic [3:0]  opcode = 4'd0;
    logic [7:0]  ip = 8'd0;
    logic [2:0]  q;
    logic        err;
    logic        halted;
    logic        retired;
    logic [15:0] retire_cnt;

    cpu_sequencer #(
        .IP_WIDTH      (8),
        .OPCODE_WIDTH  (4),
        .HALT_OPCODE   (HALT),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .ram_busy  (ram_busy),
        .opcode    (opcode),
        .ip        (ip),
        .q         (q),
        .err       (err),
        .halted    (halted),
        .retired   (retired),
        .retire_cnt(retire_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  q;
        logic        ret;
        logic [15:0] cnt;
        logic        halted;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    int          compared = 0;
    int          mismatched = 0;
    logic [15:0] model_cnt = 16'd0;

    task automatic chk(input string name, input int act, input int req);
        compared++;
        if (act != req) begin
            mismatched++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Queue the expected outputs after the coming edge, then let that edge happen.
    task automatic tick(input logic [2:0] eq, input logic eret, input logic eerr);
        exp_t e;
        if (eret && model_cnt != 16'hFFFF) model_cnt++;
        e.q      = eq;
        e.ret    = eret;
        e.cnt    = model_cnt;
        e.halted = (eq == S_HALT);
        e.err    = eerr;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        model_cnt = 16'd0;
        tick(S_RST, 1'b0, 1'b0);
        rst = 1'b0;
    endtask

    // Entered with the DUT in SREAD; ends on the edge leaving SWRITE (or SLOAD2 on halt).
    task automatic instr(input int s1, input int s2, input int s3, input logic [3:0] opc,
                         input logic [7:0] ipv, input logic run_end, output logic [2:0] endst);
        ram_busy = 1'($urandom); run = 1'($urandom); opcode = 4'($urandom); ip = 8'($urandom);
        tick(S_LOAD1, 1'b0, 1'b0);
        repeat (s1) begin ram_busy = 1'b1; run = 1'($urandom); tick(S_LOAD1, 1'b0, 1'b0); end
        ram_busy = 1'b0;
        tick(S_LOAD2, 1'b0, 1'b0);
        repeat (s2) begin ram_busy = 1'b1; opcode = 4'($urandom); tick(S_LOAD2, 1'b0, 1'b0); end
        ram_busy = 1'b0;
        opcode   = opc;
        if (opc == HALT) begin
            tick(S_HALT, 1'b0, 1'b0);
            endst = S_HALT;
            return;
        end
        tick(S_CALC, 1'b0, 1'b0);
        ram_busy = 1'($urandom); opcode = 4'($urandom);
        tick(S_WRITE, 1'b0, 1'b0);
        repeat (s3) begin
            ram_busy = 1'b1; ip = 8'($urandom); run = 1'($urandom);
            tick(S_WRITE, 1'b0, 1'b0);
        end
        ram_busy = 1'b0;
        ip       = ipv;
        run      = run_end;
        endst    = (ipv == 8'hFF) ? S_HALT : (run_end ? S_READ : S_RST);
        tick(endst, 1'b1, 1'b0);
    endtask

    // After an instruction, bring the DUT back to SREAD from wherever it ended.
    task automatic resume(input logic [2:0] st);
        if (st == S_HALT) begin
            repeat (3) begin run = 1'b1; ram_busy = 1'($urandom); tick(S_HALT, 1'b0, 1'b0); end
            do_reset();
            run = 1'b1;
            tick(S_READ, 1'b0, 1'b0);
        end else if (st == S_RST) begin
            repeat ($urandom_range(0, 2)) begin run = 1'b0; tick(S_RST, 1'b0, 1'b0); end
            run = 1'b1;
            tick(S_READ, 1'b0, 1'b0);
        end
    endtask

    always @(negedge clk) begin
        if ($time > 0 && sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("q", int'(q), int'(e.q));
            chk("retired", int'(retired), int'(e.ret));
            chk("retire_cnt", int'(retire_cnt), int'(e.cnt));
            chk("halted", int'(halted), int'(e.halted));
            chk("err", int'(err), int'(e.err));
            if (e.ret) $display("retire: cnt=%0d next_q=%0d", retire_cnt, q);
        end
    end

    logic [2:0] st;
    logic [3:0] opc;
    logic [7:0] ipv;

    initial begin
        // Reset held two cycles with noisy inputs.
        run = 1'b1; ram_busy = 1'b1;
        do_reset();
        do_reset();
        run = 1'b0; ram_busy = 1'b0;
        repeat (2) tick(S_RST, 1'b0, 1'b0);

        // Basic instruction: 0,1,2,3,4,5,1.
        run = 1'b1;
        tick(S_READ, 1'b0, 1'b0);
        instr(0, 0, 0, 4'd3, 8'h02, 1'b1, st);

        // Three stall cycles in SLOAD1.
        instr(3, 0, 0, 4'd1, 8'h03, 1'b1, st);

        // run=0 at SWRITE exit with ip=5 drops to SRST, then restart.
        instr(0, 1, 2, 4'd7, 8'h05, 1'b0, st);
        resume(st);

        // ip all-ones at SWRITE exit halts instead of wrapping, even with run=1.
        instr(1, 1, 1, 4'd2, 8'hFF, 1'b1, st);
        resume(st);

        // Halt opcode: not retired, SHALT held for 10 cycles with run=1.
        instr(0, 2, 0, HALT, 8'h10, 1'b1, st);
        repeat (10) begin run = 1'b1; ram_busy = 1'($urandom); tick(S_HALT, 1'b0, 1'b0); end
        do_reset();
        run = 1'b1;
        tick(S_READ, 1'b0, 1'b0);

        // Randomized instruction stream.
        for (int n = 0; n < 40; n++) begin
            ipv = ($urandom_range(0, 9) == 0) ? 8'hFF : 8'($urandom_range(0, 254));
            opc = ($urandom_range(0, 11) == 0) ? HALT : 4'($urandom_range(0, 14));
            instr($urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4),
                  opc, ipv, 1'($urandom_range(0, 3) != 0), st);
            resume(st);
        end

        // Reset during an SLOAD2 stall wins over everything.
        ram_busy = 1'b0;
        tick(S_LOAD1, 1'b0, 1'b0);
        tick(S_LOAD2, 1'b0, 1'b0);
        ram_busy = 1'b1;
        tick(S_LOAD2, 1'b0, 1'b0);
        do_reset();
        ram_busy = 1'b0;
        run      = 1'b0;
        tick(S_RST, 1'b0, 1'b0);

`ifdef SEQ_STALL_TIMEOUT_EN
        // 15 stalls then release: no error; 16 stalls: SERR, absorbing until reset.
        run = 1'b1;
        tick(S_READ, 1'b0, 1'b0);
        ram_busy = 1'b0;
        tick(S_LOAD1, 1'b0, 1'b0);
        repeat (15) begin ram_busy = 1'b1; tick(S_LOAD1, 1'b0, 1'b0); end
        ram_busy = 1'b0;
        tick(S_LOAD2, 1'b0, 1'b0);
        repeat (15) begin ram_busy = 1'b1; tick(S_LOAD2, 1'b0, 1'b0); end
        tick(S_ERR, 1'b0, 1'b1);
        repeat (3) begin ram_busy = 1'($urandom); tick(S_ERR, 1'b0, 1'b1); end
        do_reset();
`endif

        @(negedge clk);
        #1;
        chk("scoreboard_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/cpu_sequencer.md
CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 Parameter: IP_WIDTH, default 8, instruction-pointer width, matching the core's line-pointer width.
REQ-002 Parameter: OPCODE_WIDTH, default 4, opcode width.
REQ-003 Parameter: HALT_OPCODE, default all-ones, the opcode that stops execution.
REQ-004 Parameter: TIMEOUT_CYCLES, default 16, maximum consecutive RAM stall cycles when the timeout is compiled in.
REQ-005 The block SHALL use one clock; reset SHALL be synchronous and active-high.
REQ-006 Port: clk, input, 1, system clock, rising edge.
REQ-007 Port: rst, input, 1, synchronous active-high reset.
REQ-008 Port: run, input, 1, permission to start or continue fetching lines.
REQ-009 Port: ram_busy, input, 1, RAM not ready; stall request.
REQ-010 Port: opcode, input, OPCODE_WIDTH, opcode returned by the instruction memory.
REQ-011 Port: ip, input, IP_WIDTH, the core's current instruction pointer.
REQ-012 Port: q, output, 3 (SequencerState), state driven to the core.
REQ-013 Port: err, output, 1, sticky fault flag.
REQ-014 Port: halted, output, 1, high while q==SHALT.
REQ-015 Port: retired, output, 1, one-cycle pulse per completed instruction.
REQ-016 Port: retire_cnt, output, 16, count of retired instructions.

Function
REQ-017 State encoding SHALL be: SRST=0, SREAD=1, SLOAD1=2, SLOAD2=3, SCALC=4, SWRITE=5, SHALT=6, SERR=7.
REQ-018 q SHALL be the registered state with no combinational path from inputs to q.
REQ-019 SRST SHALL go to SREAD when run=1 and hold otherwise.
REQ-020 SREAD SHALL go to SLOAD1 unconditionally, 1 cycle.
REQ-021 SLOAD1 SHALL hold while ram_busy=1 and go to SLOAD2 otherwise.
REQ-022 In SLOAD2, while ram_busy=1 the state SHALL hold.
REQ-023 In SLOAD2 with ram_busy=0, the next state SHALL be SHALT if opcode==HALT_OPCODE and SCALC otherwise.
REQ-024 SCALC SHALL go to SWRITE unconditionally, 1 cycle.
REQ-025 SWRITE SHALL hold while ram_busy=1.
REQ-026 On SWRITE exit (ram_busy=0), the next state SHALL be chosen by priority: ip all-ones -> SHALT (no IP wrap-around); run=0 -> SRST; else SREAD.
REQ-027 SHALT and SERR SHALL be absorbing; only rst leaves them.
REQ-028 The minimum instruction latency SHALL be 5 cycles (SREAD..SWRITE) with no stalls; each stall cycle SHALL add exactly 1 cycle.
REQ-029 A stall SHALL be a cycle in SLOAD1, SLOAD2 or SWRITE with ram_busy=1; ram_busy SHALL be ignored in all other states.
REQ-030 retired SHALL pulse for 1 cycle on the clock edge leaving SWRITE.
REQ-031 retire_cnt SHALL increment on that same edge and saturate at 0xFFFF.
REQ-032 A halt opcode SHALL NOT count as retired.
REQ-033 halted SHALL equal (q==SHALT); err SHALL equal (q==SERR).
REQ-034 run falling mid-instruction SHALL NOT abort the instruction; it SHALL take effect only at SWRITE exit.

Reset
REQ-035 With rst=1 sampled at a clock edge, the block SHALL set: q=SRST, retire_cnt=0, retired=0, stall counter=0, err=0, halted=0.
REQ-036 Reset SHALL override every transition, including from SHALT, SERR and mid-stall.
REQ-037 The block SHALL NOT depend on an asynchronous reset path.

Configuration
REQ-038 With macro SEQ_STALL_TIMEOUT_EN defined: a saturating stall counter SHALL clear on any non-stall cycle.
REQ-039 With SEQ_STALL_TIMEOUT_EN defined: when a stall cycle occurs with the counter at TIMEOUT_CYCLES-1, the next state SHALL be SERR, giving err=1 after exactly TIMEOUT_CYCLES consecutive stall cycles.
REQ-040 With SEQ_STALL_TIMEOUT_EN undefined: there SHALL be no counter; stalls SHALL last indefinitely, SERR SHALL be unreachable, and err SHALL be constant 0.

Verification
REQ-041 Scenario: rst, then run=1, ram_busy=0, opcode=3, ip=0x02 -> q sequence 0,1,2,3,4,5,1; retired pulses once; retire_cnt=1.
REQ-042 Scenario: ram_busy=1 for 3 cycles on entry to SLOAD1 -> SLOAD1 held 4 cycles total; instruction latency 8 cycles.
REQ-043 Scenario: opcode=0xF at SLOAD2 -> SHALT next cycle; halted=1; retire_cnt unchanged; stays in SHALT with run=1 for 10 cycles.
REQ-044 Scenario: ip=0xFF at SWRITE exit -> SHALT, no wrap; run=0 at SWRITE with ip=0x05 -> SRST; run=1 later -> SREAD.
REQ-045 Scenario (macro defined, TIMEOUT_CYCLES=16): ram_busy=1 held in SWRITE -> err=1 exactly 16 cycles after the first stall; 15 stalls then release -> no err.
REQ-046 Scenario: rst=1 asserted during SLOAD2 with ram_busy=1 -> next edge q=SRST, retire_cnt=0, err=0.
